// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit driving the 4KB word data memory.
// Optional perf counters are built when LSU_PERF_CNT_EN is defined.
module mem_lsu #(
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [RD_W-1:0]   resp_rd,
  output logic              resp_err,
  output logic              busy,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_data_in,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [3:0]        mem_byte_enable,
  input  logic [31:0]       mem_data_out,
  output logic [31:0]       perf_loads,
  output logic [31:0]       perf_stores,
  output logic [31:0]       perf_errs
);

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    LOAD_ISSUE,
    LOAD_CAPTURE,
    RESP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic              is_store_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [RD_W-1:0]   rd_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic              accept;
  logic              f3_bad;
  logic              misal;
  logic              req_err;
  logic              sz_b;
  logic              sz_h;
  logic [3:0]        be;
  logic [31:0]       ld_data;

  assign accept = (state_q == IDLE) && req_valid;

  // Legality and natural alignment of the incoming request
  always_comb begin
    f3_bad = 1'b0;
    misal  = 1'b0;
    if (req_is_store) begin
      f3_bad = req_funct3[2] || (req_funct3[1:0] == 2'd3);
    end else begin
      f3_bad = (req_funct3 == 3'd3) ||
               (req_funct3 == 3'd6) ||
               (req_funct3 == 3'd7);
    end
    unique case (req_funct3[1:0])
      2'd1:    misal = req_addr[0];
      2'd2:    misal = (req_addr[1:0] != 2'b00);
      default: misal = 1'b0;
    endcase
    req_err = f3_bad || misal;
  end

  // Lane enables from the latched size and low address bits
  always_comb begin
    sz_b = (funct3_q[1:0] == 2'd0);
    sz_h = (funct3_q[1:0] == 2'd1);
    be   = 4'b1111;
    unique case (1'b1)
      sz_b:    be = 4'b0001 << addr_q[1:0];
      sz_h:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Memory already sign-extends; strip the upper bits for LBU/LHU
  always_comb begin
    ld_data = mem_data_out;
    if (funct3_q == 3'd4) begin
      ld_data[31:8] = '0;
    end else if (funct3_q == 3'd5) begin
      ld_data[31:16] = '0;
    end
  end

  // Next-state and memory-port outputs
  always_comb begin
    state_d         = state_q;
    mem_write_en    = 1'b0;
    mem_read_en     = 1'b0;
    mem_byte_enable = 4'b0000;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            state_d = RESP;
          end else if (req_is_store) begin
            state_d = STORE;
          end else begin
            state_d = LOAD_ISSUE;
          end
        end
      end
      STORE: begin
        mem_write_en    = !reset;
        mem_byte_enable = be;
        state_d         = RESP;
      end
      LOAD_ISSUE: begin
        mem_read_en     = !reset;
        mem_byte_enable = be;
        state_d         = LOAD_CAPTURE;
      end
      LOAD_CAPTURE: state_d = RESP;
      RESP:         state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // State register; a reset aborts any access silently
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch, taken only on the accepting edge
  always_ff @(posedge clk) begin
    if (reset) begin
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
    end else if (accept) begin
      is_store_q <= req_is_store;
      funct3_q   <= req_funct3;
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
      rd_q       <= req_rd;
      err_q      <= req_err;
    end
  end

  // Load data capture one cycle after the read strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (state_q == LOAD_CAPTURE) begin
      rdata_q <= ld_data;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign resp_valid  = (state_q == RESP);
  assign resp_err    = (state_q == RESP) && err_q;
  assign resp_rd     = rd_q;
  assign resp_rdata  = (is_store_q || err_q) ? 32'd0 : rdata_q;
  assign mem_addr    = 32'(addr_q) & ~32'd3;
  assign mem_data_in = wdata_q;

`ifdef LSU_PERF_CNT_EN
  logic [31:0] n_ld_q;
  logic [31:0] n_st_q;
  logic [31:0] n_err_q;

  // Event counters, bumped once per response
  always_ff @(posedge clk) begin
    if (reset) begin
      n_ld_q  <= '0;
      n_st_q  <= '0;
      n_err_q <= '0;
    end else if (state_q == RESP) begin
      if (err_q) begin
        n_err_q <= n_err_q + 32'd1;
      end else if (is_store_q) begin
        n_st_q <= n_st_q + 32'd1;
      end else begin
        n_ld_q <= n_ld_q + 32'd1;
      end
    end
  end

  assign perf_loads  = n_ld_q;
  assign perf_stores = n_st_q;
  assign perf_errs   = n_err_q;
`else
  assign perf_loads  = '0;
  assign perf_stores = '0;
  assign perf_errs   = '0;
`endif

endmodule
